time_core: RTL and testbench

Timekeeping core for the digital clock: divides the system clock into a 1 Hz tick and keeps a 24-hour BCD time of day. It applies the mode/field keys so minutes and hours can be set by hand. It sits directly upstream of the seven-segment scan/print stage, which consumes the six BCD digits `a..f` and the same `mk`/`k1` keys to blink the field being adjusted.

---
 rtl/time_core.sv | 142 ++++++++++++++
 tb/tb_time_core.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_core.sv
// 1 Hz prescaler, debounced set key and 24-hour BCD time of day.
// Optional hour chime output enabled by defining TIME_CHIME_EN.
module time_core #(
    parameter int DIV = 50_000_000,
    parameter int DEB = 500_000
) (
    input  logic       fs,
    input  logic       rst_n,
    input  logic [1:0] mk,
    input  logic [1:0] k1,
    input  logic       key_inc,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] e,
    output logic [3:0] f,
    output logic       sec_tick
`ifdef TIME_CHIME_EN
    ,
    output logic       chime
`endif
);

    localparam int PW = $clog2(DIV);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(DEB - 1);

    logic [PW-1:0] cnt;
    logic          adj;
    logic          adj_q;
    logic          leave;
    logic          tick;
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          armed;
    logic          inc_p;
    logic          accept;
    logic [1:0]    sv;
    logic [DW-1:0] dcnt;
    logic [3:0]    na, nb, nc, nd, ne, nf;
    logic [8:0]    sc;
    logic [8:0]    mc;
    logic [7:0]    hc;
    logic          unused_k1;

    assign unused_k1 = k1[1];
    assign adj    = (mk == 2'b10);
    assign leave  = adj_q && !adj;
    assign tick   = !adj && (cnt == PMAX);
    assign accept = (s2 != lvl) && (dcnt == DMAX);

    // returns {carry, tens, units}
    function automatic logic [8:0] inc60(input logic [3:0] t, input logic [3:0] u);
        if (u != 4'd9) return {1'b0, t, u + 4'd1};
        if (t != 4'd5) return {1'b0, t + 4'd1, 4'd0};
        return {1'b1, 8'h00};
    endfunction

    function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) return 8'h00;
        if (u == 4'd9) return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    // armed only after a synchronized low: a key held through reset is ignored
    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            sv    <= 2'b00;
            lvl   <= 1'b0;
            armed <= 1'b0;
            inc_p <= 1'b0;
            dcnt  <= '0;
        end else begin
            s1    <= key_inc;
            s2    <= s1;
            sv    <= {sv[0], 1'b1};
            inc_p <= accept && s2 && armed;
            if (sv[1] && !s2) armed <= 1'b1;
            if (s2 == lvl) begin
                dcnt <= '0;
            end else if (accept) begin
                lvl  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_comb begin
        {nf, ne, nd, nc, nb, na} = {f, e, d, c, b, a};
        sc = inc60(b, a);
        mc = inc60(d, c);
        hc = inc24(f, e);
        if (leave) begin
            nb = 4'd0;
            na = 4'd0;
        end else if (tick) begin
            {nb, na} = sc[7:0];
            if (sc[8]) begin
                {nd, nc} = mc[7:0];
                if (mc[8]) {nf, ne} = hc;
            end
        end else if (adj && inc_p) begin
            if (k1[0]) {nf, ne} = hc;
            else       {nd, nc} = mc[7:0];
        end
    end

    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            adj_q    <= 1'b0;
            sec_tick <= 1'b0;
            {f, e, d, c, b, a} <= '0;
        end else begin
            adj_q    <= adj;
            sec_tick <= tick;
            {f, e, d, c, b, a} <= {nf, ne, nd, nc, nb, na};
            if (adj || leave || tick) cnt <= '0;
            else                      cnt <= cnt + 1'b1;
        end
    end

`ifdef TIME_CHIME_EN
    logic win;
    assign win = ({nd, nc, nb} == {4'd5, 4'd9, 4'd5} && na >= 4'd5)
              || ({nd, nc, nb, na} == 16'h0000);

    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n)    chime <= 1'b0;
        else if (adj)  chime <= 1'b0;
        else if (tick) chime <= win;
    end
`endif

endmodule

// File: tb/tb_time_core.sv
// Scoreboarded bench for time_core with DIV=4, DEB=3.
// Chime checks are included when TIME_CHIME_EN is defined.
module tb_time_core;

    logic       fs = 1'b0;
    logic       rst_n;
    logic [1:0] mk;
    logic [1:0] k1;
    logic       key_inc;
    logic [3:0] a, b, c, d, e, f;
    logic       sec_tick;
`ifdef TIME_CHIME_EN
    logic       chime;
`endif
    logic [23:0] dig;

    int n_vec = 0;
    int n_bad = 0;
    int tod = 0;
    int sbq[$];

    assign dig = {f, e, d, c, b, a};

    time_core #(.DIV(4), .DEB(3)) dut (
        .fs(fs),
        .rst_n(rst_n),
        .mk(mk),
        .k1(k1),
        .key_inc(key_inc),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .e(e),
        .f(f),
        .sec_tick(sec_tick)
`ifdef TIME_CHIME_EN
        ,
        .chime(chime)
`endif
    );

    always #5 fs = ~fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic chime_of(input int s);
        int ms;
        ms = s % 3600;
        return (ms >= 3595) || (ms == 0);
    endfunction

    function automatic int adj_min(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return h * 3600 + ((m + 1) % 60) * 60 + x;
    endfunction

    function automatic int adj_hr(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return ((h + 1) % 24) * 3600 + m * 60 + x;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge fs);
        #1;
    endtask

    task automatic press();
        key_inc = 1'b1;
        step(7);
        key_inc = 1'b0;
        step(7);
    endtask

    // field must not move before the 6th edge after the raw rise
    task automatic press_chk(input string tag, input logic hr);
        key_inc = 1'b1;
        step(5);
        chk({tag, "_early"}, dig, bcd(tod));
        tod = hr ? adj_hr(tod) : adj_min(tod);
        step(1);
        chk(tag, dig, bcd(tod));
        key_inc = 1'b0;
        step(7);
    endtask

    task automatic push_run(input int n);
        for (int i = 1; i <= n; i++) sbq.push_back((tod + i) % 86400);
    endtask

    always @(negedge fs) begin
        int t;
        if (rst_n === 1'b1 && sec_tick === 1'b1) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                t = sbq.pop_front();
                chk("tick_dig", dig, bcd(t));
`ifdef TIME_CHIME_EN
                chk("tick_chime", chime, chime_of(t));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mk = 2'b00;
        k1 = 2'b00;
        key_inc = 1'b0;
        step(3);
        chk("rst_dig", dig, 0);
        chk("rst_tick", sec_tick, 0);
        rst_n = 1'b1;

        push_run(1);
        step(3);
        chk("tick_early", sec_tick, 0);
        step(1);
        chk("tick4", sec_tick, 1);
        chk("tick4_a", a, 1);
        tod = 1;
        push_run(39);
        step(39 * 4);
        tod = 40;
        chk("t40", {b, a}, 8'h40);

        mk = 2'b10;
        k1 = 2'b00;
        step(1);
        for (int i = 0; i < 59; i++) begin
            press();
            tod = adj_min(tod);
        end
        chk("min59", dig, bcd(tod));
        press_chk("min_wrap", 1'b0);
        k1 = 2'b11;
        for (int i = 0; i < 23; i++) begin
            press();
            tod = adj_hr(tod);
        end
        chk("hr23", dig, bcd(tod));
        press_chk("hr_wrap", 1'b1);

        k1 = 2'b00;
        repeat (5) begin
            key_inc = 1'b1;
            step(2);
            key_inc = 1'b0;
            step(2);
        end
        step(7);
        chk("bounce", dig, bcd(tod));
        key_inc = 1'b1;
        step(10);
        key_inc = 1'b0;
        step(7);
        tod = adj_min(tod);
        chk("hold10", dig, bcd(tod));

        k1 = 2'b01;
        for (int i = 0; i < 23; i++) begin
            press();
            tod = adj_hr(tod);
        end
        k1 = 2'b00;
        for (int i = 0; i < 58; i++) begin
            press();
            tod = adj_min(tod);
        end
        step(20);
        chk("frozen", dig, bcd(tod));
        chk("frozen_tick", sec_tick, 0);

        mk = 2'b00;
        step(1);
        tod = tod - tod % 60;
        chk("exit_clr", dig, bcd(tod));
        chk("exit_tick", sec_tick, 0);
        push_run(60);
        step(3);
        chk("exit_early", sec_tick, 0);
        step(1);
        chk("exit_first", sec_tick, 1);
        step(58 * 4);
        chk("pre_roll", dig, bcd(86399));
        step(4);
        chk("rollover", dig, 0);
        tod = 0;

        push_run(4);
        key_inc = 1'b1;
        step(8);
        key_inc = 1'b0;
        step(8);
        tod = 4;
        chk("run_press", dig, bcd(tod));

        step(3);
        mk = 2'b10;
        step(1);
        chk("enter_tick", sec_tick, 0);
        chk("enter_dig", dig, bcd(tod));
        mk = 2'b00;
        step(1);
        tod = 0;
        chk("exit2_clr", dig, bcd(tod));
        push_run(1);
        step(4);
        chk("exit2_tick", sec_tick, 1);
        tod = 1;

        mk = 2'b10;
        k1 = 2'b00;
        step(1);
        key_inc = 1'b1;
        rst_n = 1'b0;
        step(2);
        chk("rst_mid", dig, 0);
        rst_n = 1'b1;
        step(12);
        chk("held_key", dig, 0);
        key_inc = 1'b0;
        step(7);
        press();
        tod = 60;
        chk("repress", dig, bcd(tod));

`ifdef TIME_CHIME_EN
        for (int i = 0; i < 58; i++) begin
            press();
            tod = adj_min(tod);
        end
        mk = 2'b00;
        step(1);
        push_run(56);
        step(56 * 4);
        tod = tod + 56;
        chk("chime_hi", chime, 1);
        mk = 2'b10;
        step(1);
        chk("chime_adj", chime, 0);
        mk = 2'b00;
        step(1);
        tod = tod - tod % 60;
        push_run(62);
        step(62 * 4);
        tod = tod + 62;
        chk("chime_lo", chime, 0);
        chk("chime_dig", dig, bcd(tod));
`endif

        @(negedge fs);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
